// File: rtl/lsu_riscv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_riscv : load/store unit with lane alignment, extension and timeout    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lsu_riscv #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_stall_req_o,
  output logic [31:0] lsu_data_o,
  output logic        lsu_fault_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic [2:0]       size_q;
  logic             we_q, fault_q;

  logic        w_bad_size, w_misaligned, w_req_fault, w_timeout;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;

  assign w_bad_size   = (lsu_size_i == 3'd3) || (lsu_size_i[2:1] == 2'b11);
  assign w_misaligned = ((lsu_size_i[1:0] == 2'd1) && lsu_addr_i[0]) ||
                        ((lsu_size_i[1:0] == 2'd2) && (lsu_addr_i[1:0] != 2'b00));
  assign w_req_fault  = w_bad_size || w_misaligned;
  assign w_timeout    = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  // Halfword accesses are aligned, so addr[0] is zero in the half select.
  assign w_byte = data_rdata_i[{addr_q[1:0], 3'b000} +: 8];
  assign w_half = data_rdata_i[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      3'd0:    w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'd4:    w_load_ext = {24'd0, w_byte};
      3'd1:    w_load_ext = {{16{w_half[15]}}, w_half};
      3'd5:    w_load_ext = {16'd0, w_half};
      default: w_load_ext = data_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (lsu_req_i) begin
            addr_q  <= lsu_addr_i;
            wdata_q <= lsu_data_i;
            size_q  <= lsu_size_i;
            we_q    <= lsu_we_i;
            rdata_q <= '0;
            fault_q <= w_req_fault;
            cnt_q   <= '0;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (!data_gnt_i && w_timeout) fault_q <= 1'b1;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (data_rvalid_i)  rdata_q <= w_load_ext;
          else if (w_timeout) fault_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (lsu_req_i) state_d = w_req_fault ? S_DONE : S_REQ;
      S_REQ: begin
        if (data_gnt_i)     state_d = we_q ? S_DONE : S_WAIT;
        else if (w_timeout) state_d = S_DONE;
      end
      S_WAIT: if (data_rvalid_i || w_timeout) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lsu_stall_req_o = lsu_req_i && (state_q != S_DONE);
    lsu_data_o      = rdata_q;
    lsu_fault_o     = fault_q;
    data_req_o      = 1'b0;
    data_we_o       = 1'b0;
    data_be_o       = 4'b0000;
    data_addr_o     = '0;
    data_wdata_o    = '0;
    if (state_q == S_REQ) begin
      data_req_o  = 1'b1;
      data_we_o   = we_q;
      data_addr_o = {addr_q[31:2], 2'b00};
      case (size_q[1:0])
        2'd0: begin
          data_be_o    = 4'b0001 << addr_q[1:0];
          data_wdata_o = {4{wdata_q[7:0]}};
        end
        2'd1: begin
          data_be_o    = 4'b0011 << {addr_q[1], 1'b0};
          data_wdata_o = {2{wdata_q[15:0]}};
        end
        default: begin
          data_be_o    = 4'b1111;
          data_wdata_o = wdata_q;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/lsu_riscv.md
Name: lsu_riscv

Overview:
Load/store unit between the instruction decoder / ALU stage and the data-memory port. Consumes the decoded memory control (req, we, size) and the ALU-computed address. Issues a req/gnt/rvalid transaction to data memory. Performs byte-lane alignment and sign/zero extension. Holds the core stalled until the access completes, faults or times out.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in REQ+WAIT_RVALID before fault; 0 disables the timeout.

Ports:
clk_i  in  1  clock, all state updates on rising edge
rstn_i  in  1  reset, synchronous, active-low
lsu_req_i  in  1  memory op requested (decoder mem_req); held by core while stalled
lsu_we_i  in  1  1=store, 0=load
lsu_size_i  in  3  funct3 size code: B=0, H=1, W=2, BU=4, HU=5
lsu_addr_i  in  32  byte address from ALU
lsu_data_i  in  32  store data (rs2)
lsu_stall_req_o  out  1  core stall request
lsu_data_o  out  32  extended load result, valid in DONE
lsu_fault_o  out  1  misaligned / bad size / timeout, valid in DONE
data_req_o  out  1  memory request
data_we_o  out  1  memory write enable
data_be_o  out  4  byte enables
data_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
data_wdata_o  out  32  lane-replicated store data
data_gnt_i  in  1  memory accepted request
data_rvalid_i  in  1  read data valid
data_rdata_i  in  32  read data

Behaviour:
- Reset (rstn_i=0 at edge): state IDLE, timeout counter 0, captured regs 0, all registered outputs 0. Reset mid-transaction abandons it; data_req_o is 0 from the next cycle.
- FSM states: IDLE, REQ, WAIT_RVALID, DONE.
- lsu_stall_req_o = lsu_req_i & (state != DONE). This is combinational, so the stall is raised in the same cycle the request appears.
- IDLE + lsu_req_i:
  - Capture addr, we, size, wdata.
  - Bad size (3, 6, 7), H/HU with addr[0]=1, or W with addr[1:0]!=0: go to DONE with fault=1, lsu_data_o=0. No memory access.
  - Otherwise go to REQ.
- REQ:
  - data_req_o=1. data_addr_o, data_we_o, data_be_o and data_wdata_o are driven from the captured regs and held stable until gnt.
  - On gnt: a store goes to DONE; a load goes to WAIT_RVALID.
  - data_req_o drops the cycle after gnt.
- WAIT_RVALID: on rvalid, register the extended data into lsu_data_o and go to DONE. rvalid is ignored in all other states; memory returns rvalid at least 1 cycle after gnt.
- DONE:
  - Stall is low for exactly one cycle and the core advances.
  - lsu_data_o and lsu_fault_o are valid this cycle and hold until the next capture.
  - The next state is always IDLE, so back-to-back ops cost one IDLE cycle.
- Byte enables: B/BU give 4'b0001<<addr[1:0]; H/HU give 4'b0011<<{addr[1],1'b0}; W gives 4'b1111.
- Store data: B gives {4{d[7:0]}}; H gives {2{d[15:0]}}; W gives d.
- Load extract:
  - B/BU: byte select rdata[8*addr[1:0]+:8].
  - H/HU: half select rdata[16*addr[1]+:16].
  - B/H sign-extend; BU/HU zero-extend; W passes rdata through unchanged.
- Timeout: the counter is cleared on entering REQ and increments each cycle in REQ or WAIT_RVALID. Reaching TIMEOUT_CYCLES goes to DONE with fault=1, lsu_data_o=0 and data_req_o dropped. Late gnt/rvalid arrivals are ignored.
- lsu_req_i dropped while in REQ or WAIT_RVALID (flush): the transaction still runs to DONE and the result is discarded. Stall follows lsu_req_i.
- gnt and timeout in the same cycle: gnt wins.

Test Plan:
- Store W: addr=0x104, d=0xDEADBEEF, gnt 2 cycles after req -> data_addr_o=0x104, be=1111, wdata=0xDEADBEEF; stall high 3 cycles, low 1 cycle in DONE; fault=0.
- Load B: addr=0x203, rdata=0x80FF_1234, gnt+1, rvalid+1 -> be=1000, lsu_data_o=0xFFFFFF80. Repeat as BU -> 0x00000080.
- Load H: addr=0x12, rdata=0x8001_7FFF -> be=1100, lsu_data_o=0xFFFF8001. Same access at addr=0x10 -> 0x00007FFF.
- Misaligned W at 0x2 and bad size 3 -> no data_req_o ever; DONE next cycle with fault=1.
- TIMEOUT_CYCLES=4, gnt never asserted -> fault=1 in DONE after 4 REQ cycles; data_req_o drops. A late gnt is ignored.
- rstn_i=0 during WAIT_RVALID -> next cycle state IDLE, all outputs 0. A fresh load after reset completes normally.
